// File: rtl/oled_refresh.sv
// oled_refresh: streams one 128x64 frame (8 pages x (3 command bytes +
// 128 data bytes)) from a 1 KiB frame buffer to the SPI byte transmitter.
// Optional build macro OLED_REFRESH_CONTINUOUS_EN: when defined, START held
// high at the end of a frame chains straight into the next frame.
module oled_refresh #(
  parameter int PAGES = 8,
  parameter int COLS  = 128
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic [9:0] fb_addr,
  output logic       fb_rd,
  input  logic [7:0] fb_data,
  output logic       spi_start,
  input  logic       spi_done,
  output logic [9:0] spi_data
);

  localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);
  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD_ISSUE,
    CMD_WAIT,
    FETCH,
    FETCH_WAIT,
    DATA_ISSUE,
    DATA_WAIT,
    FRAME_END
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] page_reg, page_next;
  logic [6:0] col_reg, col_next;
  logic [1:0] cmd_reg, cmd_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic [9:0] fb_addr_reg, fb_addr_next;
  logic       fb_rd_reg, fb_rd_next;
  logic       spi_start_reg, spi_start_next;
  logic [9:0] spi_data_reg, spi_data_next;
  logic       last_byte;

  // Page-addressing preamble: set page, column low nibble 0, column high nibble 0.
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [2:0] page);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {5'b10110, page};
      2'd1:    b = 8'h00;
      default: b = 8'h10;
    endcase
    return b;
  endfunction

  assign last_byte = (page_reg == PAGE_LAST) && (col_reg == COL_LAST);

  // State, counters and all outputs are registered; outputs follow the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      page_reg      <= 3'd0;
      col_reg       <= 7'd0;
      cmd_reg       <= 2'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fb_addr_reg   <= 10'd0;
      fb_rd_reg     <= 1'b0;
      spi_start_reg <= 1'b0;
      spi_data_reg  <= 10'h000;
    end else begin
      state_reg     <= state_next;
      page_reg      <= page_next;
      col_reg       <= col_next;
      cmd_reg       <= cmd_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      fb_addr_reg   <= fb_addr_next;
      fb_rd_reg     <= fb_rd_next;
      spi_start_reg <= spi_start_next;
      spi_data_reg  <= spi_data_next;
    end
  end

  // Next-state and next-output decode; strobes default low, data/address hold.
  always_comb begin
    state_next     = state_reg;
    page_next      = page_reg;
    col_next       = col_reg;
    cmd_next       = cmd_reg;
    done_next      = 1'b0;
    fb_addr_next   = fb_addr_reg;
    fb_rd_next     = 1'b0;
    spi_start_next = 1'b0;
    spi_data_next  = spi_data_reg;

    case (state_reg)
      IDLE: begin
        if (START) begin
          state_next     = CMD_ISSUE;
          page_next      = 3'd0;
          cmd_next       = 2'd0;
          spi_start_next = 1'b1;
          spi_data_next  = {2'b00, cmd_byte(2'd0, 3'd0)};
        end
      end
      CMD_ISSUE: state_next = CMD_WAIT;
      CMD_WAIT: begin
        if (spi_done) begin
          if (cmd_reg == 2'd2) begin
            state_next   = FETCH;
            col_next     = 7'd0;
            fb_rd_next   = 1'b1;
            fb_addr_next = {page_reg, 7'd0};
          end else begin
            state_next     = CMD_ISSUE;
            cmd_next       = cmd_reg + 2'd1;
            spi_start_next = 1'b1;
            spi_data_next  = {2'b00, cmd_byte(cmd_reg + 2'd1, page_reg)};
          end
        end
      end
      FETCH: state_next = FETCH_WAIT;
      FETCH_WAIT: begin
        // Frame-buffer read data is valid this cycle; forward it straight out.
        state_next     = DATA_ISSUE;
        spi_start_next = 1'b1;
        spi_data_next  = {last_byte, 1'b1, fb_data};
      end
      DATA_ISSUE: state_next = DATA_WAIT;
      DATA_WAIT: begin
        if (spi_done) begin
          if (col_reg != COL_LAST) begin
            state_next   = FETCH;
            col_next     = col_reg + 7'd1;
            fb_rd_next   = 1'b1;
            fb_addr_next = {page_reg, col_reg + 7'd1};
          end else if (page_reg != PAGE_LAST) begin
            state_next     = CMD_ISSUE;
            page_next      = page_reg + 3'd1;
            cmd_next       = 2'd0;
            spi_start_next = 1'b1;
            spi_data_next  = {2'b00, cmd_byte(2'd0, page_reg + 3'd1)};
          end else begin
            state_next = FRAME_END;
            done_next  = 1'b0;
          end
          if ((col_reg == COL_LAST) && (page_reg == PAGE_LAST)) begin
            done_next = 1'b1;
          end
        end
      end
      FRAME_END: begin
`ifdef OLED_REFRESH_CONTINUOUS_EN
        if (START) begin
          state_next     = CMD_ISSUE;
          page_next      = 3'd0;
          cmd_next       = 2'd0;
          spi_start_next = 1'b1;
          spi_data_next  = {2'b00, cmd_byte(2'd0, 3'd0)};
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign fb_addr   = fb_addr_reg;
  assign fb_rd     = fb_rd_reg;
  assign spi_start = spi_start_reg;
  assign spi_data  = spi_data_reg;

endmodule

// File: tb/tb_oled_refresh.sv
// tb_oled_refresh: directed bench for oled_refresh with an SPI ack model
// (ack 5 cycles after each spi_start) and a frame-buffer model
// (mem[a] = a[7:0] ^ 8'h5A, data valid exactly one cycle after fb_rd).
module tb_oled_refresh;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic       BUSY;
  logic       DONE;
  logic [9:0] fb_addr;
  logic       fb_rd;
  logic [7:0] fb_data;
  logic       spi_start;
  logic       spi_done;
  logic [9:0] spi_data;

  logic ack_pulse;
  logic stray_pulse;
  logic idle_stray;
  assign spi_done = ack_pulse | stray_pulse | idle_stray;

  oled_refresh #(.PAGES(8), .COLS(128)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .fb_addr   (fb_addr),
    .fb_rd     (fb_rd),
    .fb_data   (fb_data),
    .spi_start (spi_start),
    .spi_done  (spi_done),
    .spi_data  (spi_data)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // monitor statistics (written only by the monitor process)
  int n_start, n_done, seq_err, lat_err, addr_err, ovl_err, early_drop, done_err;
  int rd_count, last_ack_cyc, last_rd_cyc, cyc;
  logic [9:0] log_mem [0:2199];
  // requests from the main process (written only there)
  int clr_seq = 0;
  int inj_seq = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem8(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // expected spi_data for transfer i of a frame
  function automatic logic [9:0] exp_word(input int i);
    int p, k;
    logic [7:0] b;
    logic [9:0] a;
    p = i / 131;
    k = i % 131;
    if (k < 3) begin
      case (k)
        0:       b = 8'hB0 | 8'(p);
        1:       b = 8'h00;
        default: b = 8'h10;
      endcase
      return {2'b00, b};
    end
    a = 10'(p * 128 + (k - 3));
    return {(a == 10'd1023), 1'b1, mem8(a)};
  endfunction

  // SPI / memory models and protocol monitor, all on the falling edge
  initial begin : monitor
    int ack_cnt, clr_seen, inj_seen, idx;
    logic rd_prev, arm, inj_pending, busy_prev, done_prev;
    logic [9:0] addr_prev;
    ack_cnt = 0; clr_seen = 0; inj_seen = 0;
    rd_prev = 0; arm = 0; inj_pending = 0; busy_prev = 0; done_prev = 0;
    addr_prev = 0; ack_pulse = 0; stray_pulse = 0; fb_data = 8'hEE; cyc = 0;
    n_start = 0; n_done = 0; seq_err = 0; lat_err = 0; addr_err = 0;
    ovl_err = 0; early_drop = 0; done_err = 0; rd_count = 0;
    last_ack_cyc = -100; last_rd_cyc = -100;
    forever begin
      @(negedge CLK);
      if (clr_seen != clr_seq) begin
        clr_seen = clr_seq;
        n_start = 0; n_done = 0; seq_err = 0; lat_err = 0; addr_err = 0;
        ovl_err = 0; early_drop = 0; done_err = 0; rd_count = 0;
        last_ack_cyc = -100; last_rd_cyc = -100;
      end
      if (inj_seen != inj_seq) begin
        inj_seen = inj_seq;
        inj_pending = 1'b1;
      end
      // observe (ack_pulse still holds the value the DUT sampled last edge)
      if (ack_pulse) last_ack_cyc = cyc - 1;
      if (fb_rd) begin
        if (fb_addr !== rd_count[9:0]) addr_err++;
        if (last_ack_cyc != cyc - 1) lat_err++;
        last_rd_cyc = cyc;
        rd_count++;
      end
      if (spi_start) begin
        idx = n_start;
        if (idx < 2200) log_mem[idx] = spi_data;
        if (spi_data !== exp_word(idx % 1048)) seq_err++;
        if (ack_cnt != 0) ovl_err++;
        if (spi_data[8]) begin
          if (last_rd_cyc != cyc - 2) lat_err++;
        end else if ((idx % 1048) != 0) begin
          if (last_ack_cyc != cyc - 1) lat_err++;
        end
        n_start++;
      end
      if (DONE) begin
        n_done++;
        if (done_prev) done_err++;
        if (last_ack_cyc != cyc - 1) lat_err++;
      end
      if (busy_prev && !BUSY && RST_N && !done_prev) early_drop++;
      busy_prev = BUSY;
      done_prev = DONE;
      // drive model outputs for the coming edge
      if (!RST_N) begin
        ack_cnt = 0; ack_pulse = 0; stray_pulse = 0; arm = 0;
        rd_prev = 0; fb_data = 8'hEE;
      end else begin
        ack_pulse = 1'b0;
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) ack_pulse = 1'b1;
        end
        if (spi_start) ack_cnt = 5;
        fb_data = rd_prev ? mem8(addr_prev) : 8'hEE;
        rd_prev = fb_rd;
        addr_prev = fb_addr;
        stray_pulse = arm;
        arm = 1'b0;
        if (inj_pending && fb_rd) begin
          arm = 1'b1;
          inj_pending = 1'b0;
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_stats();
    clr_seq++;
    step();
  endtask

  task automatic wait_done(input int tgt, input int budget);
    for (int i = 0; i < budget && n_done < tgt; i++) step();
    check("done_seen", n_done, tgt);
  endtask

  task automatic wait_starts(input int tgt, input int budget);
    for (int i = 0; i < budget && n_start < tgt; i++) step();
    check("starts_reached", 32'(n_start >= tgt), 1);
  endtask

  task automatic frame_checks(input int starts, input int dones);
    check("spi_start_count", n_start, starts);
    check("done_count", n_done, dones);
    check("seq_errors", seq_err, 0);
    check("latency_errors", lat_err, 0);
    check("fb_addr_errors", addr_err, 0);
    check("overlap_errors", ovl_err, 0);
    check("busy_early_drop", early_drop, 0);
    check("done_width_errors", done_err, 0);
    check("idle_busy", BUSY, 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, BUSY, 0);
    check({pfx, "_done"}, DONE, 0);
    check({pfx, "_spi_start"}, spi_start, 0);
    check({pfx, "_spi_data"}, spi_data, 10'h000);
    check({pfx, "_fb_rd"}, fb_rd, 0);
    check({pfx, "_fb_addr"}, fb_addr, 10'h000);
  endtask

  initial begin : main
    RST_N = 1'b0;
    START = 1'b0;
    idle_stray = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    RST_N = 1'b1;
    repeat (2) step();

    // stray spi_done while idle
    clear_stats();
    idle_stray = 1'b1;
    step();
    idle_stray = 1'b0;
    repeat (10) step();
    check("idle_stray_starts", n_start, 0);
    check("idle_stray_busy", BUSY, 0);

    // frame 1: plain frame, START latency, content
    clear_stats();
    START = 1'b1;
    step();
    START = 1'b0;
    check("start_lat_spi_start", spi_start, 1);
    check("start_lat_spi_data", spi_data, 10'h0B0);
    check("start_lat_busy", BUSY, 1);
    wait_done(1, 20000);
    check("busy_low_after_done", BUSY, 0);
    repeat (5) step();
    frame_checks(1048, 1);
    check("word0", log_mem[0], 10'h0B0);
    check("word1", log_mem[1], 10'h000);
    check("word2", log_mem[2], 10'h010);
    check("word3", log_mem[3], 10'h15A);
    check("page3_preamble", log_mem[393], 10'h0B3);
    check("last_word", log_mem[1047], 10'h3A5);

    // frame 2: START pulses mid-frame, stray spi_done in FETCH_WAIT
    clear_stats();
    START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 20000 && n_done < 1; i++) begin
      START = (n_start < 1000 && (i % 300) == 150);
      if ((i % 900) == 100) inj_seq++;
      step();
    end
    START = 1'b0;
    check("mash_done_seen", n_done, 1);
    repeat (5) step();
    frame_checks(1048, 1);

    // frame 3: reset during page 2 data, then a clean frame
    clear_stats();
    START = 1'b1;
    step();
    START = 1'b0;
    wait_starts(2 * 131 + 20, 10000);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) step();
    RST_N = 1'b1;
    clear_stats();
    repeat (30) step();
    check("post_reset_starts", n_start, 0);
    check("post_reset_busy", BUSY, 0);
    START = 1'b1;
    step();
    START = 1'b0;
    check("restart_word0", spi_data, 10'h0B0);
    wait_done(1, 20000);
    repeat (5) step();
    frame_checks(1048, 1);
    check("restart_log0", log_mem[0], 10'h0B0);

    // frame 4: START held high across the frame end
    clear_stats();
    START = 1'b1;
    step();
    wait_done(1, 20000);
`ifdef OLED_REFRESH_CONTINUOUS_EN
    check("cont_busy_held", BUSY, 1);
    wait_starts(2048, 20000);
    START = 1'b0;
    wait_done(2, 20000);
    repeat (5) step();
    frame_checks(2096, 2);
    check("cont_second_preamble", log_mem[1048], 10'h0B0);
`else
    check("single_busy_drop", BUSY, 0);
    START = 1'b0;
    repeat (20) step();
    frame_checks(1048, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_refresh.md
# oled_refresh

Frame-refresh sequencer for the SSD1306-class 128x64 OLED path. After panel init has completed, it streams one full frame from an external 1 KiB frame-buffer memory to the panel: 8 pages, each a 3-byte addressing command preamble followed by 128 display-data bytes. It sits directly upstream of the SPI byte transmitter and drives that transmitter's `spi_start`/`spi_done`/`spi_data` handshake, as the init sequencer does during power-up. The top level muxes the two sources onto the SPI.

## Interface
Parameters:
- `PAGES`, 8: pages per frame; page index width is 3 bits.
- `COLS`, 128: data bytes per page; column index width is 7 bits.

Ports:
- One clock; reset is asynchronous and active-low.
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RST_N` in 1: asynchronous active-low reset.
- `START` in 1: frame request; sampled only in IDLE.
- `BUSY` out 1: high from the cycle after an accepted START until return to IDLE.
- `DONE` out 1: one-cycle pulse when the last byte of a frame is acknowledged.
- `fb_addr` out 10: frame-buffer byte address, `{page[2:0], col[6:0]}`.
- `fb_rd` out 1: one-cycle read strobe.
- `fb_data` in 8: read data, valid exactly one cycle after `fb_rd`.
- `spi_start` out 1: one-cycle transfer request to the SPI transmitter.
- `spi_done` in 1: one-cycle completion pulse from the SPI transmitter.
- `spi_data` out 10: `{cs_release, dc, byte[7:0]}`. `dc` is 0 for a command and 1 for data. `cs_release` is 1 only on the final byte of a frame.

## Operation
- States: IDLE, CMD_ISSUE, CMD_WAIT, FETCH, FETCH_WAIT, DATA_ISSUE, DATA_WAIT, FRAME_END.
- Reset values: `BUSY`=0, `DONE`=0, `spi_start`=0, `spi_data`=10'h000, `fb_rd`=0, `fb_addr`=0. Page, column and command counters are 0. State is IDLE.
- IDLE: START=1 moves to CMD_ISSUE and clears the page counter.
- Per-page command preamble for page p, in order: 0xB0|p, 0x00, 0x10. Each is sent with `dc`=0 and `cs_release`=0.
- CMD_ISSUE pulses `spi_start` with the command byte, then goes to CMD_WAIT.
- CMD_WAIT on `spi_done`:
  - goes to CMD_ISSUE for the next command, or
  - after the third command, clears the column counter and goes to FETCH.
- FETCH pulses `fb_rd` with `fb_addr={p,col}`, then goes to FETCH_WAIT.
- FETCH_WAIT captures `fb_data`, then goes to DATA_ISSUE.
- DATA_ISSUE pulses `spi_start` with `{last, 1'b1, byte}`, where `last` = (p==7 && col==127). It then goes to DATA_WAIT.
- DATA_WAIT on `spi_done`:
  - col<127: increment col, go to FETCH.
  - col==127, p<7: increment p, clear the command counter, go to CMD_ISSUE.
  - col==127, p==7: go to FRAME_END.
- FRAME_END pulses `DONE` for one cycle and returns to IDLE (see Configuration).
- Total transfers per frame: 8×(3+128) = 1048.
- Counter arithmetic is unsigned. Col wraps 127→0 and page wraps 7→0 only via the explicit transitions above; no carry leaks into `fb_addr`.
- `spi_done` outside CMD_WAIT/DATA_WAIT is ignored.
- START while BUSY is ignored.
- Reset mid-frame aborts immediately: all outputs return to reset values and there is no resume. The SPI transmitter is reset by the same `RST_N`.

## Timing
- Accepted START at cycle T: `BUSY`=1 and first `spi_start` (10'h0B0) in T+1.
- Command `spi_done` at cycle N: next command `spi_start` at N+1.
- Data path after a `spi_done` at cycle N: `fb_rd` at N+1, `fb_data` sampled at N+2, `spi_start` at N+3.
- `spi_data` is registered and held stable from its `spi_start` cycle until the next `spi_start`.
- Final data `spi_done` at cycle N: `DONE`=1 at N+1, `BUSY`=0 at N+2.
- `spi_start` is never asserted while a transfer is outstanding.

## Configuration
- Macro: `OLED_REFRESH_CONTINUOUS_EN`.
- Defined: in FRAME_END, `DONE` pulses. If START=1 that cycle, the block goes directly to CMD_ISSUE with page 0 and `BUSY` stays 1. Otherwise it goes to IDLE.
- Undefined: FRAME_END always returns to IDLE, giving one frame per accepted START.

## Test plan
- Single frame: SPI model acks 5 cycles after each `spi_start`; memory holds mem[a]=a[7:0]^8'h5A. Expect:
  - exactly 1048 `spi_start` pulses;
  - first four `spi_data` = 10'h0B0, 10'h000, 10'h010, 10'h15A;
  - page-3 preamble starts with 10'h0B3;
  - last `spi_data` = 10'h3A5 (mem[1023]=8'hFF^8'h5A, cs_release=1);
  - one `DONE` pulse.
- Latency: START at T → `spi_start` at T+1. Data `spi_done` at N → `fb_rd` N+1, `spi_start` N+3, `fb_addr` incrementing by 1 within a page.
- START pulsed repeatedly mid-frame → ignored; transfer count remains 1048 and `BUSY` never drops early.
- Assert `RST_N`=0 during page 2 data → all outputs 0 asynchronously. After release, no `spi_start` until a new START, and the new frame begins with 10'h0B0.
- Stray `spi_done` pulses while in IDLE and FETCH_WAIT → no state change, no extra `spi_start`.
- With `OLED_REFRESH_CONTINUOUS_EN` and START held high: two back-to-back frames, 2096 transfers, two `DONE` pulses, `BUSY` continuously 1. Drop START before the second FRAME_END → IDLE. Without the macro: one frame only.
